// File: rtl/proj_pkg.sv
// Shared definitions for the vertex projection block: configuration
// constants, FSM states, the captured-vertex record and small helpers.
`timescale 1ns/1ps

package proj_pkg;

    // Geometry and number formats
    localparam int COORD_W    = 24;   // signed camera-space coordinate width
    localparam int FRAC_W     = 8;    // input fractional bits (1.0 = 256)
    localparam int RECIP_FRAC = 16;   // fractional bits of the reciprocal
    localparam int RECIP_W    = 24;   // reciprocal width and divider step count
    localparam int FOCAL      = 160;  // focal length in pixels
    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int OUT_W      = 9;    // width of each output coordinate
    localparam int NEAR_Z     = 256;  // near plane in input units

    // Screen centre from the screen extent
    function automatic int centre(input int extent);
        return extent / 2;
    endfunction

    // Number of bits needed to hold a non-negative value
    function automatic int bits_for(input int value);
        int b;
        b = 1;
        while ((1 << b) <= value) b++;
        return b;
    endfunction

    localparam int CX      = centre(SCREEN_W);
    localparam int CY      = centre(SCREEN_H);
    // Full signed product of a coordinate and the zero-extended reciprocal
    localparam int PROD_W  = COORD_W + RECIP_W + 1;
    // Shifted product plus screen centre, with headroom for the add
    localparam int WIDE_W  = PROD_W - RECIP_FRAC + 1;
    localparam int OUT_MAX = (1 << OUT_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV,
        ST_MULX,
        ST_MULY,
        ST_OUT
    } state_t;

    // Vertex as captured at acceptance, depth already clamped to the near plane
    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic        [COORD_W-1:0] zc;
        logic                      last;
    } vertex_t;

endpackage

// File: rtl/recip_div.sv
// Unsigned restoring divider: quot = num / den, one quotient bit per
// cycle, NUM_W cycles from start to done. done is a one-cycle pulse and
// the quotient holds until the next start.
`timescale 1ns/1ps

module recip_div
    import proj_pkg::*;
#(
    parameter int NUM_W = 24,
    parameter int DEN_W = 24
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [NUM_W-1:0] num_in,
    input  logic [DEN_W-1:0] den_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [NUM_W-1:0] quot_out
);

    localparam int CNT_W = bits_for(NUM_W);

    logic [DEN_W-1:0] r_rem;
    logic [NUM_W-1:0] r_quot;   // numerator bits shift out, quotient bits shift in
    logic [DEN_W-1:0] r_den;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [DEN_W:0]   w_trial;
    logic [DEN_W:0]   w_diff;
    logic             w_fits;

    assign w_trial = {r_rem, r_quot[NUM_W-1]};
    assign w_diff  = w_trial - {1'b0, r_den};
    assign w_fits  = (w_trial >= {1'b0, r_den});

    // One restoring step per cycle while busy; start reloads and aborts any run
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_in) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start_in) begin
            r_rem  <= '0;
            r_quot <= num_in;
            r_den  <= den_in;
            r_cnt  <= CNT_W'(NUM_W);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_fits ? DEN_W'(w_diff) : DEN_W'(w_trial);
            r_quot <= {r_quot[NUM_W-2:0], w_fits};
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy_out = r_busy;
    assign done_out = r_done;
    assign quot_out = r_quot;

endmodule

// File: rtl/vert_proj_fx.sv
// Fixed-point perspective projection of one vertex per transaction:
// reciprocal of clamped depth by iterative division, then x and y scaled
// through one shared multiplier and offset to the screen centre.
// Optional build macro VERT_PROJ_CLIP_EN: screen coordinates saturate to
// the visible area and clip_out flags near-plane or saturation events.
`timescale 1ns/1ps

module vert_proj_fx
    import proj_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [2:0][COORD_W-1:0] coor_in,
    input  logic                    valid_in,
    input  logic                    last_in,
    output logic                    ready_out,
    output logic [2:0][OUT_W-1:0]   coor_out,
    output logic                    valid_out,
    output logic                    last_out,
    input  logic                    ready_in
`ifdef VERT_PROJ_CLIP_EN
    ,
    output logic                    clip_out
`endif
);

    localparam logic        [RECIP_W-1:0] RECIP_NUM = RECIP_W'(FOCAL << RECIP_FRAC);
    localparam logic signed [COORD_W-1:0] NEAR_Z_S  = COORD_W'(NEAR_Z);
    localparam logic signed [WIDE_W-1:0]  CX_S      = WIDE_W'(CX);
    localparam logic signed [WIDE_W-1:0]  CY_S      = WIDE_W'(CY);

    state_t r_state;
    state_t w_state_nxt;

    vertex_t                   r_vtx;
    logic signed [WIDE_W-1:0]  r_ox;
    logic [2:0][OUT_W-1:0]     r_coor_out;
    logic                      r_last_out;

    logic                      w_ready;
    logic                      w_accept;
    logic signed [COORD_W-1:0] w_z_in;
    logic                      w_near;
    logic        [COORD_W-1:0] w_zc;
    logic                      w_div_busy;
    logic                      w_div_done;
    logic        [RECIP_W-1:0] w_recip;
    logic signed [COORD_W-1:0] w_mul_a;
    logic signed [PROD_W-1:0]  w_a_ext;
    logic signed [PROD_W-1:0]  w_r_ext;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [WIDE_W-1:0]  w_o_now;
    logic signed [WIDE_W-1:0]  w_sx;
    logic signed [WIDE_W-1:0]  w_sy;
    logic        [COORD_W-1:0] w_dz_wide;
    logic        [OUT_W-1:0]   w_sx_out;
    logic        [OUT_W-1:0]   w_sy_out;
    logic        [OUT_W-1:0]   w_dz_out;

    assign w_ready  = (r_state == ST_IDLE);
    assign w_accept = w_ready && valid_in && !w_div_busy;

    // Depth clamp on the incoming vertex feeds the divider at acceptance
    assign w_z_in = $signed(coor_in[0]);
    assign w_near = (w_z_in < NEAR_Z_S);
    assign w_zc   = w_near ? NEAR_Z_S : w_z_in;

    recip_div #(
        .NUM_W (RECIP_W),
        .DEN_W (COORD_W)
    ) u_recip_div (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (w_accept),
        .num_in   (RECIP_NUM),
        .den_in   (w_zc),
        .busy_out (w_div_busy),
        .done_out (w_div_done),
        .quot_out (w_recip)
    );

    // Shared multiplier: x in MULX, y in MULY; floor shift keeps sign
    assign w_mul_a = (r_state == ST_MULY) ? r_vtx.y : r_vtx.x;
    assign w_a_ext = PROD_W'(w_mul_a);
    assign w_r_ext = PROD_W'($signed({1'b0, w_recip}));
    assign w_prod  = w_a_ext * w_r_ext;
    assign w_o_now = WIDE_W'(w_prod >>> RECIP_FRAC);

    assign w_sx      = CX_S + r_ox;
    assign w_sy      = CY_S + w_o_now;
    assign w_dz_wide = r_vtx.zc >> FRAC_W;
    assign w_dz_out  = (w_dz_wide > COORD_W'(OUT_MAX)) ? OUT_W'(OUT_MAX) : OUT_W'(w_dz_wide);

`ifdef VERT_PROJ_CLIP_EN
    logic r_near;
    logic r_clip_out;
    logic w_sat;
    localparam logic signed [WIDE_W-1:0] SX_MAX = WIDE_W'(SCREEN_W - 1);
    localparam logic signed [WIDE_W-1:0] SY_MAX = WIDE_W'(SCREEN_H - 1);

    // Saturate screen coordinates to the visible area and flag any clamp
    always_comb begin
        w_sx_out = OUT_W'(w_sx);
        w_sy_out = OUT_W'(w_sy);
        w_sat    = 1'b0;
        if (w_sx < 0) begin
            w_sx_out = '0;
            w_sat    = 1'b1;
        end else if (w_sx > SX_MAX) begin
            w_sx_out = OUT_W'(SCREEN_W - 1);
            w_sat    = 1'b1;
        end
        if (w_sy < 0) begin
            w_sy_out = '0;
            w_sat    = 1'b1;
        end else if (w_sy > SY_MAX) begin
            w_sy_out = OUT_W'(SCREEN_H - 1);
            w_sat    = 1'b1;
        end
    end

    // Near-plane flag travels with the vertex; clip result registers with the outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_near     <= 1'b0;
            r_clip_out <= 1'b0;
        end else begin
            if (w_accept) r_near <= w_near;
            if (r_state == ST_MULY) r_clip_out <= r_near | w_sat;
        end
    end

    assign clip_out = r_clip_out;
`else
    // Without clipping the screen coordinates wrap modulo 2^OUT_W
    assign w_sx_out = OUT_W'(w_sx);
    assign w_sy_out = OUT_W'(w_sy);
`endif

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // FSM next state: accept, divide, two multiplies, hold output until taken
    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = ST_DIV;
            ST_DIV:  if (w_div_done) w_state_nxt = ST_MULX;
            ST_MULX:                 w_state_nxt = ST_MULY;
            ST_MULY:                 w_state_nxt = ST_OUT;
            ST_OUT:  if (ready_in)   w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture vertex, keep ox, register the finished coordinates
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vtx      <= '0;
            r_ox       <= '0;
            r_coor_out <= '0;
            r_last_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vtx.x    <= $signed(coor_in[2]);
                r_vtx.y    <= $signed(coor_in[1]);
                r_vtx.zc   <= w_zc;
                r_vtx.last <= last_in;
            end
            if (r_state == ST_MULX) r_ox <= w_o_now;
            if (r_state == ST_MULY) begin
                r_coor_out[2] <= w_sx_out;
                r_coor_out[1] <= w_sy_out;
                r_coor_out[0] <= w_dz_out;
                r_last_out    <= r_vtx.last;
            end
        end
    end

    assign ready_out = w_ready;
    assign valid_out = (r_state == ST_OUT);
    assign coor_out  = r_coor_out;
    assign last_out  = r_last_out;

endmodule

// File: tb/tb_vert_proj_fx.sv
// Directed bench for vert_proj_fx: hand-computed vectors for the nominal
// case, near-plane clamp, negative offsets, depth saturation, coordinate
// wrap/saturation, output stall, back-to-back objects and mid-run reset.
`timescale 1ns/1ps

module tb_vert_proj_fx;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic [2:0][23:0] coor_in;
    logic             valid_in;
    logic             last_in;
    logic             ready_out;
    logic [2:0][8:0]  coor_out;
    logic             valid_out;
    logic             last_out;
    logic             ready_in;
`ifdef VERT_PROJ_CLIP_EN
    logic             clip_out;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0       = 0;

    localparam int LAT = 27;   // RECIP_W + 3 edges from acceptance to valid_out

    vert_proj_fx dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .coor_in   (coor_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .ready_out (ready_out),
        .coor_out  (coor_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .ready_in  (ready_in)
`ifdef VERT_PROJ_CLIP_EN
        ,
        .clip_out  (clip_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one vertex when the block is ready; returns at the negedge after acceptance
    task automatic send(input int x, input int y, input int z, input logic last);
        int n;
        n = 0;
        while (ready_out !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("send_ready", ready_out, 1);
        coor_in[2] = 24'(x);
        coor_in[1] = 24'(y);
        coor_in[0] = 24'(z);
        last_in    = last;
        valid_in   = 1'b1;
        @(negedge clk_in);
        t0       = cyc;
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (valid_out !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_valid"}, valid_out, 1);
    endtask

    task automatic check_out(input string tag, input int ex, input int ey, input int ed,
                             input logic el, input int lat);
        wait_valid(tag);
        if (lat > 0) check({tag, "_lat"}, cyc - t0, lat);
        check({tag, "_x"}, coor_out[2], ex);
        check({tag, "_y"}, coor_out[1], ey);
        check({tag, "_d"}, coor_out[0], ed);
        check({tag, "_last"}, last_out, el);
    endtask

    task automatic handshake(input string tag);
        ready_in = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
        check({tag, "_vdrop"}, valid_out, 0);
        check({tag, "_rdy"}, ready_out, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0;
        coor_in  = '0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        ready_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Reset values
        check("rst_ready", ready_out, 1);
        check("rst_valid", valid_out, 0);
        check("rst_last", last_out, 0);
        check("rst_coor", coor_out, 0);
`ifdef VERT_PROJ_CLIP_EN
        check("rst_clip", clip_out, 0);
`endif
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Nominal: r=20480, ox=80 -> (240,120), depth 2
        send(256, 0, 512, 1'b0);
        check_out("a", 240, 120, 2, 1'b0, LAT);
`ifdef VERT_PROJ_CLIP_EN
        check("a_clip", clip_out, 0);
`endif
        handshake("a");

        // oy=-160 -> sy=-40
        send(0, -256, 256, 1'b1);
`ifdef VERT_PROJ_CLIP_EN
        check_out("b", 160, 0, 1, 1'b1, LAT);
        check("b_clip", clip_out, 1);
`else
        check_out("b", 160, 472, 1, 1'b1, LAT);
`endif
        handshake("b");

        // z=0 clamps to 256: r=40960, ox=128*40960>>16=80
        send(128, 0, 0, 1'b0);
        check_out("c", 240, 120, 1, 1'b0, LAT);
`ifdef VERT_PROJ_CLIP_EN
        check("c_clip", clip_out, 1);
`endif
        handshake("c");

        // Far depth: 2097152>>8=8192 saturates to 511
        send(0, 0, 2097152, 1'b0);
        check_out("dsat", 160, 120, 511, 1'b0, LAT);
`ifdef VERT_PROJ_CLIP_EN
        check("dsat_clip", clip_out, 0);
`endif
        handshake("dsat");

        // ox=640 -> sx=800: wraps to 288, or saturates to 319
        send(1024, 0, 256, 1'b0);
`ifdef VERT_PROJ_CLIP_EN
        check_out("wrap", 319, 120, 1, 1'b0, LAT);
        check("wrap_clip", clip_out, 1);
`else
        check_out("wrap", 288, 120, 1, 1'b0, LAT);
`endif
        handshake("wrap");

        // Stall: r=10240, ox=-80, oy=40 -> (80,160), depth 4; junk input ignored
        send(-512, 256, 1024, 1'b1);
        wait_valid("stall");
        coor_in[2] = 24'd7;
        coor_in[1] = 24'd7;
        coor_in[0] = 24'd700;
        last_in    = 1'b0;
        valid_in   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            check("stall_x", coor_out[2], 80);
            check("stall_y", coor_out[1], 160);
            check("stall_d", coor_out[0], 4);
            check("stall_last", last_out, 1);
            check("stall_valid", valid_out, 1);
            check("stall_rdy", ready_out, 0);
        end
`ifdef VERT_PROJ_CLIP_EN
        check("stall_clip", clip_out, 0);
`endif
        valid_in = 1'b0;
        handshake("stall");
        repeat (3) @(negedge clk_in);
        check("stall_noq_valid", valid_out, 0);
        check("stall_noq_rdy", ready_out, 1);

        // Back-to-back object of three vertices, last on the third
        ready_in = 1'b0;
        send(256, 256, 512, 1'b0);
        check_out("b2b0", 240, 200, 2, 1'b0, LAT);
        handshake("b2b0");
        send(-256, -256, 2048, 1'b0);
        check_out("b2b1", 140, 100, 8, 1'b0, LAT);
        handshake("b2b1");
        // r=13653, ox=floor(20.83)=20, oy=floor(-20.83)=-21
        send(100, -100, 768, 1'b1);
        check_out("b2b2", 180, 99, 3, 1'b1, LAT);
        handshake("b2b2");

        // Reset in the middle of the division
        send(256, 256, 512, 1'b1);
        repeat (5) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_ready", ready_out, 1);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_last", last_out, 0);
        check("mid_rst_coor", coor_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (30) @(negedge clk_in);
        check("post_rst_valid", valid_out, 0);
        send(256, 0, 512, 1'b1);
        check_out("post_rst", 240, 120, 2, 1'b1, LAT);
        handshake("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
